// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: resolves memory wait,
// EX redirect and load-use hazards by priority, with wait timeout and counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_flush,
  output logic             id_ex_pause,
  output logic             id_ex_flush,
  output logic             ex_mem_pause,
  output logic             mem_wb_flush,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              mem_stall, load_use;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  always_comb begin
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_pause  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_pause = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    terr_d       = terr_q;
    stall_d      = stall_q;
    flush_d      = flush_q;

    if (state_q == FAULT) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_pause = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      if (mem_stall) begin
        // EX/ID are frozen, so redirect and load-use get re-evaluated on release
        pc_pause     = 1'b1;
        if_id_pause  = 1'b1;
        id_ex_pause  = 1'b1;
        ex_mem_pause = 1'b1;
        mem_wb_flush = 1'b1;
        wait_cnt_d   = wait_cnt_q + 1'b1;
        if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WC_LAST)) begin
          state_d = FAULT;
          terr_d  = 1'b1;
        end else begin
          state_d = MEM_WAIT;
        end
      end else begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
        end else if (load_use) begin
          pc_pause    = 1'b1;
          if_id_pause = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      if (pc_pause && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
    end

    // Pipeline registers reset themselves; keep controls quiet meanwhile
    if (rst) begin
      pc_pause     = 1'b0;
      if_id_pause  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_pause  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_pause = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      terr_q     <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      terr_q     <= terr_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign timeout_err  = terr_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic       pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush;
  logic       ex_mem_pause, mem_wb_flush, timeout_err;
  logic [3:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // {pc_p, ifid_p, ifid_f, idex_p, idex_f, exmem_p, memwb_f}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1101011;
  localparam logic [6:0] C_RED  = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;

  logic [6:0] ctl;
  assign ctl = {pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush,
                ex_mem_pause, mem_wb_flush};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_flush(if_id_flush),
    .id_ex_pause(id_ex_pause), .id_ex_flush(id_ex_flush), .ex_mem_pause(ex_mem_pause),
    .mem_wb_flush(mem_wb_flush), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to the next negedge, then settle combinational outputs
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    step(); clr(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  task automatic set_lu5();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2_used = 1'b1; id_rs2 = 5'd5;
  endtask

  task automatic set_stall();
    mem_req = 1'b1; mem_ready = 1'b0;
  endtask

  initial begin
    clr(); rst = 1'b1;
    // Controls stay 0 in reset even with all hazards present
    set_stall(); ex_redirect = 1'b1; set_lu5();
    settle();
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    step(); step();
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_events), 32'd0);
    clr(); rst = 1'b0;

    // Load-use on rs2, one cycle
    step(); set_lu5(); settle();
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    step(); clr(); settle();
    chk("lu_next", 32'(ctl), 32'(C_NONE));
    chk("lu_stall", 32'(stall_cycles), 32'd1);

    // x0 destination and unused operand never stall
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1; settle();
    chk("x0_ctl", 32'(ctl), 32'(C_NONE));
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0; settle();
    chk("unused_ctl", 32'(ctl), 32'(C_NONE));
    id_rs1_used = 1'b1; settle();
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));

    // Redirect outranks load-use
    do_reset();
    set_lu5(); ex_redirect = 1'b1; settle();
    chk("red_ctl", 32'(ctl), 32'(C_RED));
    step(); clr(); settle();
    chk("red_flush", 32'(flush_events), 32'd1);
    chk("red_stall", 32'(stall_cycles), 32'd0);

    // Three-cycle memory wait, redirect ignored while waiting
    do_reset();
    set_stall(); settle();
    chk("mw1_ctl", 32'(ctl), 32'(C_MEM));
    step(); ex_redirect = 1'b1; settle();
    chk("mw2_ctl", 32'(ctl), 32'(C_MEM));
    step(); settle();
    chk("mw3_ctl", 32'(ctl), 32'(C_MEM));
    step(); ex_redirect = 1'b0; mem_ready = 1'b1; settle();
    chk("mw_rel_ctl", 32'(ctl), 32'(C_NONE));
    chk("mw_stall", 32'(stall_cycles), 32'd3);
    chk("mw_flush", 32'(flush_events), 32'd0);
    step(); clr(); ex_redirect = 1'b1; settle();
    chk("mw_run_ctl", 32'(ctl), 32'(C_RED));
    // Wait counter cleared: another 3-cycle wait must not fault
    step(); clr(); set_stall();
    step(); step();
    step(); mem_ready = 1'b1;
    step(); clr(); settle();
    chk("mw_again_terr", 32'(timeout_err), 32'd0);
    chk("mw_again_stall", 32'(stall_cycles), 32'd6);

    // Timeout after four consecutive wait cycles
    do_reset();
    set_stall(); settle();
    chk("to1_ctl", 32'(ctl), 32'(C_MEM));
    step(); step(); step(); settle();
    chk("to4_ctl", 32'(ctl), 32'(C_MEM));
    chk("to4_terr", 32'(timeout_err), 32'd0);
    step(); clr(); mem_ready = 1'b1; ex_redirect = 1'b1; settle();
    chk("to5_terr", 32'(timeout_err), 32'd1);
    chk("fault_ctl", 32'(ctl), 32'(C_MEM));
    chk("fault_stall", 32'(stall_cycles), 32'd4);
    step(); settle();
    chk("fault_hold_ctl", 32'(ctl), 32'(C_MEM));
    chk("fault_freeze", 32'(stall_cycles), 32'd4);
    chk("fault_flush", 32'(flush_events), 32'd0);
    rst = 1'b1; settle();
    chk("fault_rst_ctl", 32'(ctl), 32'(C_NONE));
    step(); rst = 1'b0; settle();
    chk("post_rst_terr", 32'(timeout_err), 32'd0);
    chk("post_rst_stall", 32'(stall_cycles), 32'd0);
    chk("post_rst_ctl", 32'(ctl), 32'(C_RED));

    // Ready arriving on the would-be timeout cycle avoids FAULT
    do_reset();
    set_stall();
    step(); step();
    step(); mem_ready = 1'b1; settle();
    chk("near_to_ctl", 32'(ctl), 32'(C_NONE));
    step(); clr(); ex_redirect = 1'b1; settle();
    chk("near_to_terr", 32'(timeout_err), 32'd0);
    chk("near_to_run", 32'(ctl), 32'(C_RED));

    // Saturation of both counters
    do_reset();
    set_lu5();
    for (int i = 0; i < 20; i++) step();
    settle();
    chk("sat_stall", 32'(stall_cycles), 32'd15);
    step(); settle();
    chk("sat_stall_hold", 32'(stall_cycles), 32'd15);
    clr(); ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) step();
    settle();
    chk("sat_flush", 32'(flush_events), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage RISC-V pipeline. It drives the pause and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources by fixed priority: multi-cycle data-memory wait, taken control transfer resolved in EX, and load-use dependency. It also enforces a memory-wait timeout and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 255, consecutive memory-wait cycles before entering FAULT; 0 disables the timeout
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
mem_req  in  1  MEM-stage instruction has an active data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_pause  out  1  hold PC
if_id_pause  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_pause  out  1  hold ID/EX
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_pause  out  1  hold EX/MEM
mem_wb_flush  out  1  load bubble into MEM/WB
timeout_err  out  1  sticky; set on entry to FAULT
stall_cycles  out  CNT_W  saturating count of stall cycles
flush_events  out  CNT_W  saturating count of redirect flushes

Behaviour:
- State register: RUN, MEM_WAIT, FAULT. Reset state RUN; wait_cnt=0; timeout_err=0; both counters 0.
- While rst=1, all pause and flush outputs are 0. The pipeline registers apply their own reset.
- Control outputs are combinational from state and current inputs, so they take effect at the same clock edge.
- Definitions:
  - mem_stall = mem_req & ~mem_ready
  - load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
- Priority 1, mem_stall (state RUN or MEM_WAIT):
  - pc_pause, if_id_pause, id_ex_pause, ex_mem_pause = 1; mem_wb_flush = 1.
  - All other flush outputs are 0. ex_redirect and load_use are ignored because EX and ID are held and re-evaluated after release.
- Priority 2, ex_redirect with no mem_stall: if_id_flush = 1, id_ex_flush = 1, no pauses.
  - A concurrent load_use is ignored because the ID instruction is squashed.
  - flush_events += 1.
- Priority 3, load_use with no mem_stall and no ex_redirect: pc_pause = 1, if_id_pause = 1, id_ex_flush = 1.
  - Exactly one stall cycle. The inserted bubble clears the hazard on the next cycle.
- Otherwise all control outputs are 0.
- stall_cycles += 1 in every non-reset cycle in RUN or MEM_WAIT where pc_pause = 1.
- Both counters saturate at all ones; there is no wrap.
- Transitions:
  - RUN -> MEM_WAIT on mem_stall.
  - MEM_WAIT -> RUN on ~mem_stall; wait_cnt clears to 0.
  - wait_cnt increments on each mem_stall cycle.
  - If MEM_TIMEOUT != 0 and mem_stall and wait_cnt == MEM_TIMEOUT-1, the next state is FAULT. The FAULT transition occurs after exactly MEM_TIMEOUT consecutive stall cycles.
- FAULT:
  - pc_pause, if_id_pause, id_ex_pause, ex_mem_pause, mem_wb_flush = 1 regardless of inputs; all other flushes 0; timeout_err = 1.
  - Counters freeze.
  - The only exit is rst.
- mem_ready arriving in the same cycle as the timeout edge: no mem_stall, so the state returns to RUN and FAULT is not entered.
- Reset asserted mid-stall or in FAULT: the next cycle is RUN with counters and timeout_err cleared.
- ex_rd = 0 never causes a load-use stall.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2_used=1, id_rs2=5 for 1 cycle -> that cycle pc_pause=if_id_pause=id_ex_flush=1; next cycle (ex_mem_read=0) all 0; stall_cycles=1.
- x0 and unused operand: ex_rd=0 matching id_rs1=0, or id_rs1==ex_rd with id_rs1_used=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 together with a load_use match -> if_id_flush=id_ex_flush=1, pc_pause=0, flush_events=1, stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> four pauses plus mem_wb_flush=1 for exactly 3 cycles; ex_redirect=1 during the wait gives no flush; stall_cycles=3; state back to RUN.
- Timeout with MEM_TIMEOUT=4: mem_stall held 4 cycles -> timeout_err=1 from cycle 5, and outputs stay paused after mem_ready=1; rst for 1 cycle -> timeout_err=0 and counters 0. Same test with mem_ready=1 in cycle 4 -> no FAULT.
- Saturation: with CNT_W=4, hold load_use for 20 cycles -> stall_cycles=15 and stays at 15.
